ram_arbiter: RTL and testbench



---
 rtl/ram_arbiter_pkg.sv | 6 +
 rtl/ram_arbiter_defs.vh | 8 +
 rtl/rr_arbiter2.sv | 13 +
 rtl/ram_arbiter.sv | 108 ++++++++++
 tb/tb_ram_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and state encodings for the two-port RAM arbiter.
package ram_arbiter_pkg;
    `include "ram_arbiter_defs.vh"

    typedef logic [1:0] state_t;
endpackage

// File: rtl/ram_arbiter_defs.vh
// FSM state encodings shared by the arbiter package and anything decoding the state.
`ifndef RAM_ARBITER_DEFS_VH
`define RAM_ARBITER_DEFS_VH
localparam logic [1:0] IDLE   = 2'd0;
localparam logic [1:0] SETUP  = 2'd1;
localparam logic [1:0] STROBE = 2'd2;
localparam logic [1:0] DONE   = 2'd3;
`endif

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: lone requester wins; on a tie the port not served last wins.
// Purely combinational, no latency; no backpressure of its own.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       pick
);
    always_comb begin
        valid = |req;
        pick  = (req == 2'b11) ? ~last_grant : req[1];
    end
endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port async-read RAM between fetch (port 0) and data (port 1) with setup/strobe/hold writes.
// Ack two edges after the sampling edge, one access per four cycles; requesters hold req until ack.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int addr_bits = 16,
    parameter int data_bits = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 p0_req,
    input  logic                 p0_write,
    input  logic [addr_bits-1:0] p0_address,
    input  logic [data_bits-1:0] p0_data_in,
    output logic                 p0_ack,
    output logic [data_bits-1:0] p0_data_out,
    input  logic                 p1_req,
    input  logic                 p1_write,
    input  logic [addr_bits-1:0] p1_address,
    input  logic [data_bits-1:0] p1_data_in,
    output logic                 p1_ack,
    output logic [data_bits-1:0] p1_data_out,
    output logic                 ram_write_enable,
    output logic [addr_bits-1:0] ram_address,
    output logic [data_bits-1:0] ram_data_in,
    input  logic [data_bits-1:0] ram_data_out,
    output logic                 busy,
    output logic                 grant
);
    state_t state, next_state;
    logic   last_grant;
    logic   op_write;
    logic   arb_valid;
    logic   arb_pick;

    rr_arbiter2 u_arb (
        .req        ({p1_req, p0_req}),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .pick       (arb_pick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (arb_valid) next_state = SETUP;
            SETUP:   next_state = STROBE;
            STROBE:  next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Every RAM-facing signal is a flop, so the RAM never sees a req-to-output glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant       <= 1'b1;
            grant            <= 1'b0;
            op_write         <= 1'b0;
            ram_write_enable <= 1'b0;
            ram_address      <= '0;
            ram_data_in      <= '0;
            p0_ack           <= 1'b0;
            p1_ack           <= 1'b0;
            p0_data_out      <= '0;
            p1_data_out      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant       <= arb_pick;
                        op_write    <= arb_pick ? p1_write   : p0_write;
                        ram_address <= arb_pick ? p1_address : p0_address;
                        ram_data_in <= arb_pick ? p1_data_in : p0_data_in;
                    end
                end
                SETUP: begin
                    ram_write_enable <= op_write;
                end
                STROBE: begin
                    ram_write_enable <= 1'b0;
                    if (!op_write) begin
                        if (grant) p1_data_out <= ram_data_out;
                        else       p0_data_out <= ram_data_out;
                    end
                    if (grant) p1_ack <= 1'b1;
                    else       p0_ack <= 1'b1;
                end
                default: begin
                    p0_ack     <= 1'b0;
                    p1_ack     <= 1'b0;
                    last_grant <= grant;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM and an ack-driven scoreboard.
module tb_ram_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        p0_req, p0_write, p1_req, p1_write;
    logic [15:0] p0_address, p1_address;
    logic [7:0]  p0_data_in, p1_data_in;
    logic        p0_ack, p1_ack;
    logic [7:0]  p0_data_out, p1_data_out;
    logic        ram_write_enable;
    logic [15:0] ram_address;
    logic [7:0]  ram_data_in, ram_data_out;
    logic        busy, grant;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_write(p0_write), .p0_address(p0_address), .p0_data_in(p0_data_in),
        .p0_ack(p0_ack), .p0_data_out(p0_data_out),
        .p1_req(p1_req), .p1_write(p1_write), .p1_address(p1_address), .p1_data_in(p1_data_in),
        .p1_ack(p1_ack), .p1_data_out(p1_data_out),
        .ram_write_enable(ram_write_enable), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .busy(busy), .grant(grant)
    );

    logic [7:0] mem [0:65535];
    assign ram_data_out = mem[ram_address];
    always @(posedge clk) if (ram_write_enable) mem[ram_address] <= ram_data_in;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         port;
        bit         rd;
        logic [7:0] data;
    } exp_t;
    exp_t       sbq[$];
    logic [7:0] mdout [2];
    int         p1_ack_cnt = 0;

    function automatic void push(input bit port, input bit rd, input logic [7:0] data);
        exp_t e;
        e.port = port; e.rd = rd; e.data = data;
        sbq.push_back(e);
    endfunction

    // Monitor: pops one expectation per ack and tracks the data_out model.
    always @(negedge clk) begin
        if (reset_n) begin
            if (p0_ack && p1_ack) begin
                check("dual_ack", 1, 0);
            end else if (p0_ack || p1_ack) begin
                automatic bit port = p1_ack;
                if (port) p1_ack_cnt++;
                if (sbq.size() == 0) begin
                    check("unexpected_ack_port", port, 1'bx);
                end else begin
                    automatic exp_t e = sbq.pop_front();
                    check("ack_owner", port, e.port);
                    check("grant_on_ack", grant, e.port);
                    if (e.rd) mdout[e.port] = e.data;
                end
            end
            check("p0_data_out", p0_data_out, mdout[0]);
            check("p1_data_out", p1_data_out, mdout[1]);
        end
    end

    // Write-strobe checker: one-cycle enable with address stable before and after.
    logic        prev_we = 1'b0;
    logic [15:0] prev_addr = '0, we_addr = '0;
    int          we_len = 0, we_cnt = 0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (ram_write_enable && !prev_we) begin
                check("we_addr_setup", ram_address, prev_addr);
                we_addr = ram_address;
                we_len  = 1;
                we_cnt++;
            end else if (ram_write_enable) begin
                we_len++;
            end else if (prev_we) begin
                check("we_len", we_len, 1);
                check("we_addr_hold", ram_address, we_addr);
            end
            prev_we   = ram_write_enable;
            prev_addr = ram_address;
        end
    end

    bit busy_on = 1'b0;
    int busy_total = 0, busy_run = 0, busy_max = 0;
    always @(negedge clk) begin
        if (busy_on) begin
            if (busy) begin
                busy_total++;
                busy_run++;
                if (busy_run > busy_max) busy_max = busy_run;
            end else begin
                busy_run = 0;
            end
        end
    end

    task automatic access(input bit port, input bit wr, input logic [15:0] a,
                          input logic [7:0] d, output int lat);
        lat = -1;
        if (port == 1'b0) begin
            p0_write = wr; p0_address = a; p0_data_in = d; p0_req = 1'b1;
        end else begin
            p1_write = wr; p1_address = a; p1_data_in = d; p1_req = 1'b1;
        end
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if ((port == 1'b0 && p0_ack) || (port == 1'b1 && p1_ack)) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) check("ack_timeout", 0, 1);
        else begin
            @(posedge clk); #1;
        end
        if (port == 1'b0) p0_req = 1'b0;
        else              p1_req = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        p0_req = 1'b0; p1_req = 1'b0;
        #1;
        check("rst_ram", {ram_write_enable, ram_address, ram_data_in}, 0);
        check("rst_ports", {p0_ack, p1_ack, p0_data_out, p1_data_out, busy, grant}, 0);
        sbq.delete();
        mdout[0] = '0; mdout[1] = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, snap, lat1;
        reset_n = 1'b0;
        p0_req = 0; p0_write = 0; p0_address = '0; p0_data_in = '0;
        p1_req = 0; p1_write = 0; p1_address = '0; p1_data_in = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'h5A;
        mem[16'h0020] = 8'h11; mem[16'h0021] = 8'h22; mem[16'h0022] = 8'h33;
        mem[16'h0030] = 8'hA1; mem[16'h0031] = 8'hB2; mem[16'h0032] = 8'hC4;
        mdout[0] = '0; mdout[1] = '0;
        @(posedge clk); #1;
        do_reset();

        // Single read from port 0
        snap = we_cnt;
        push(0, 1, 8'h5A);
        access(0, 0, 16'h0010, 8'h00, lat);
        check("t1_latency", lat, 3);
        check("t1_no_we", we_cnt - snap, 0);

        // Port 1 write then read at the top address
        snap = we_cnt;
        push(1, 0, 8'h00);
        access(1, 1, 16'hFFFF, 8'hC3, lat);
        push(1, 1, 8'hC3);
        access(1, 0, 16'hFFFF, 8'h00, lat);
        check("t2_we_pulses", we_cnt - snap, 1);
        check("t2_mem", mem[16'hFFFF], 8'hC3);

        // Simultaneous requests from reset: port 0 first
        do_reset();
        push(0, 1, 8'h5A);
        push(1, 1, 8'hC3);
        busy_total = 0; busy_run = 0; busy_max = 0; busy_on = 1'b1;
        fork
            access(0, 0, 16'h0010, 8'h00, lat);
            access(1, 0, 16'hFFFF, 8'h00, lat1);
        join
        busy_on = 1'b0;
        check("t3_busy_total", busy_total, 6);
        check("t3_busy_run", busy_max, 3);

        // Both ports held for six accesses: strict alternation
        push(0, 1, 8'h11); push(1, 1, 8'hA1);
        push(0, 1, 8'h22); push(1, 1, 8'hB2);
        push(0, 1, 8'h33); push(1, 1, 8'hC4);
        fork
            begin
                int l0;
                for (int i = 0; i < 3; i++) access(0, 0, 16'h0020 + 16'(i), 8'h00, l0);
            end
            begin
                int l1;
                for (int j = 0; j < 3; j++) access(1, 0, 16'h0030 + 16'(j), 8'h00, l1);
            end
        join

        // Reset during the strobe of a port 1 write
        p1_write = 1'b1; p1_address = 16'h1234; p1_data_in = 8'h77; p1_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5_we_strobe", ram_write_enable, 1);
        #1 reset_n = 1'b0;
        #1;
        check("t5_we_async", ram_write_enable, 0);
        check("t5_busy_async", busy, 0);
        check("t5_ack_async", {p0_ack, p1_ack}, 0);
        p1_req = 1'b0;
        sbq.delete();
        mdout[0] = '0; mdout[1] = '0;
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        push(0, 1, 8'h5A);
        push(1, 1, 8'hC3);
        fork
            access(0, 0, 16'h0010, 8'h00, lat);
            access(1, 0, 16'hFFFF, 8'h00, lat1);
        join

        // Port 0 write then read with port 1 idle
        do_reset();
        snap = p1_ack_cnt;
        push(0, 0, 8'h00);
        access(0, 1, 16'h0040, 8'h9E, lat);
        push(0, 1, 8'h9E);
        access(0, 0, 16'h0040, 8'h00, lat);
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_p1_ack", p1_ack_cnt - snap, 0);
        check("t6_p1_dout", p1_data_out, 8'h00);
        check("t6_p0_dout", p0_data_out, 8'h9E);

        check("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
